// File: rtl/memory_responder_pkg.sv
// Shared constants and loader state encoding for the memory responder.
package memory_responder_pkg;

   localparam int unsigned WORD_LEN      = 32;
   localparam int unsigned START_ADDR    = 0;
   localparam int unsigned DEFAULT_DEPTH = 16384;

   typedef enum logic {
      LD_LOAD = 1'b0,
      LD_RUN  = 1'b1
   } ld_state_e;

endpackage

// File: rtl/memory_loader.sv
// Byte-stream program loader: packs little-endian bytes into words and emits a word write port.
module memory_loader
   import memory_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH,
   parameter int unsigned SKIP_LOAD   = 0,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [7:0]          ld_byte,
   input  logic                ld_last,
   output logic                we,
   output logic [AW-1:0]       windex,
   output logic [WORD_LEN-1:0] wword,
   output ld_state_e           state,
   output logic                ld_overflow
);

   localparam ld_state_e RST_STATE = (SKIP_LOAD != 0) ? LD_RUN : LD_LOAD;
   localparam logic [AW:0] PTR_RST = (AW+1)'(START_ADDR);

   ld_state_e           r_state, w_state_d;
   logic [1:0]          r_byte_cnt, w_byte_cnt_d;
   logic [23:0]         r_wbuf, w_wbuf_d;
   logic [AW:0]         r_ptr, w_ptr_d;
   logic                r_overflow, w_overflow_d;
   logic [WORD_LEN-1:0] w_word;
   logic                w_accept;
   logic                w_commit;
   logic                w_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RST_STATE;
         r_byte_cnt <= 2'd0;
         r_wbuf     <= 24'h0;
         r_ptr      <= PTR_RST;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_byte_cnt <= w_byte_cnt_d;
         r_wbuf     <= w_wbuf_d;
         r_ptr      <= w_ptr_d;
         r_overflow <= w_overflow_d;
      end
   end

   // Word as it would be committed now: current byte in its lane, higher lanes zero.
   always_comb begin
      w_word = '0;
      case (r_byte_cnt)
         2'd0:    w_word = {24'h0, ld_byte};
         2'd1:    w_word = {16'h0, ld_byte, r_wbuf[7:0]};
         2'd2:    w_word = {8'h0, ld_byte, r_wbuf[15:0]};
         default: w_word = {ld_byte, r_wbuf};
      endcase
   end

   assign w_accept = (r_state == LD_LOAD) && ld_valid;
   assign w_commit = w_accept && ((r_byte_cnt == 2'd3) || ld_last);
   // ptr has one spare bit; its MSB set means the array is full.
   assign w_full   = r_ptr[AW];

   always_comb begin
      w_state_d    = r_state;
      w_byte_cnt_d = r_byte_cnt;
      w_wbuf_d     = r_wbuf;
      w_ptr_d      = r_ptr;
      w_overflow_d = r_overflow;
      if (w_accept) begin
         if (w_commit) begin
            w_byte_cnt_d = 2'd0;
            w_wbuf_d     = 24'h0;
            if (w_full) begin
               w_overflow_d = 1'b1;
            end else begin
               w_ptr_d = r_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (ld_last) begin
               w_state_d = LD_RUN;
            end
         end else begin
            w_byte_cnt_d = r_byte_cnt + 2'd1;
            w_wbuf_d     = w_word[23:0];
         end
      end
   end

   assign ld_ready    = (r_state == LD_LOAD);
   assign we          = w_commit && !w_full;
   assign windex      = r_ptr[AW-1:0];
   assign wword       = w_word;
   assign state       = r_state;
   assign ld_overflow = r_overflow;

endmodule

// File: rtl/memory_responder.sv
// Unified instruction/data word array with combinational reads, filled by a byte-stream loader.
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH,
   parameter int unsigned SKIP_LOAD   = 0,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr_i,
   output logic [31:0] inst,
   input  logic [31:0] addr_d,
   output logic [31:0] rdata,
   input  logic        wen,
   input  logic [31:0] wdata,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [7:0]  ld_byte,
   input  logic        ld_last,
   output logic        core_rst_n,
   output logic        load_done,
   output logic        ld_overflow
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   logic [WORD_LEN-1:0] r_mem [DEPTH_WORDS];
   logic                r_core_rst_n;

   logic                w_ld_we;
   logic [AW-1:0]       w_ld_index;
   logic [WORD_LEN-1:0] w_ld_word;
   ld_state_e           w_state;
   logic                w_mem_we;
   logic [AW-1:0]       w_mem_idx;
   logic [WORD_LEN-1:0] w_mem_data;
   logic                w_unused_addr;

   memory_loader #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .SKIP_LOAD   (SKIP_LOAD),
      .AW          (AW)
   ) u_loader (
      .clk         (clk),
      .rst_n       (rst_n),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_byte     (ld_byte),
      .ld_last     (ld_last),
      .we          (w_ld_we),
      .windex      (w_ld_index),
      .wword       (w_ld_word),
      .state       (w_state),
      .ld_overflow (ld_overflow)
   );

   // The loader owns the write port in LOAD; the core owns it in RUN.
   assign w_mem_we   = (w_state == LD_LOAD) ? w_ld_we : wen;
   assign w_mem_idx  = (w_state == LD_LOAD) ? w_ld_index : addr_d[AW+1:2];
   assign w_mem_data = (w_state == LD_LOAD) ? w_ld_word : wdata;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_idx] <= w_mem_data;
      end
   end

   assign inst  = r_mem[addr_i[AW+1:2]];
   assign rdata = r_mem[addr_d[AW+1:2]];

   // Lags load_done by one cycle so the last loaded word is settled before the core starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_core_rst_n <= 1'b0;
      end else begin
         r_core_rst_n <= (w_state == LD_RUN);
      end
   end

   assign core_rst_n    = r_core_rst_n;
   assign load_done     = (w_state == LD_RUN);
   assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0], addr_d[31:AW+2], addr_d[1:0]};

endmodule

// File: tb/tb_memory_responder.sv
// Randomised bench for memory_responder against a word-array reference model.
module tb_memory_responder;

   localparam int unsigned MainDepth = 64;
   localparam int unsigned OvfDepth  = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr_i, addr_d, wdata;
   logic        wen;
   logic        ld_valid, ld_last, sel_ovf;
   logic [7:0]  ld_byte;

   logic [31:0] m_inst, m_rdata, o_inst, o_rdata;
   logic        m_ld_ready, m_core_rst_n, m_load_done, m_ld_overflow;
   logic        o_ld_ready, o_core_rst_n, o_load_done, o_ld_overflow;
   logic [31:0] s_unused_inst, s_unused_rdata;
   logic        s_unused_ld_ready, s_unused_ovf, s_core_rst_n, s_load_done;

   logic [31:0] c_inst, c_rdata;
   logic        c_ld_ready, c_core_rst_n, c_load_done, c_ld_overflow;

   logic [7:0]  stream [32];
   logic [31:0] exp_mem [MainDepth];
   bit          exp_valid [MainDepth];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   memory_responder #(.DEPTH_WORDS(MainDepth)) dut (
      .clk (clk), .rst_n (rst_n), .addr_i (addr_i), .inst (m_inst), .addr_d (addr_d),
      .rdata (m_rdata), .wen (wen), .wdata (wdata), .ld_valid (ld_valid && !sel_ovf),
      .ld_ready (m_ld_ready), .ld_byte (ld_byte), .ld_last (ld_last),
      .core_rst_n (m_core_rst_n), .load_done (m_load_done), .ld_overflow (m_ld_overflow)
   );

   memory_responder #(.DEPTH_WORDS(OvfDepth)) dut_ovf (
      .clk (clk), .rst_n (rst_n), .addr_i (addr_i), .inst (o_inst), .addr_d (addr_d),
      .rdata (o_rdata), .wen (1'b0), .wdata (wdata), .ld_valid (ld_valid && sel_ovf),
      .ld_ready (o_ld_ready), .ld_byte (ld_byte), .ld_last (ld_last),
      .core_rst_n (o_core_rst_n), .load_done (o_load_done), .ld_overflow (o_ld_overflow)
   );

   memory_responder #(.DEPTH_WORDS(16), .SKIP_LOAD(1)) dut_skip (
      .clk (clk), .rst_n (rst_n), .addr_i (addr_i), .inst (s_unused_inst), .addr_d (addr_d),
      .rdata (s_unused_rdata), .wen (1'b0), .wdata (wdata), .ld_valid (1'b0),
      .ld_ready (s_unused_ld_ready), .ld_byte (ld_byte), .ld_last (ld_last),
      .core_rst_n (s_core_rst_n), .load_done (s_load_done), .ld_overflow (s_unused_ovf)
   );

   assign c_inst        = sel_ovf ? o_inst : m_inst;
   assign c_rdata       = sel_ovf ? o_rdata : m_rdata;
   assign c_ld_ready    = sel_ovf ? o_ld_ready : m_ld_ready;
   assign c_core_rst_n  = sel_ovf ? o_core_rst_n : m_core_rst_n;
   assign c_load_done   = sel_ovf ? o_load_done : m_load_done;
   assign c_ld_overflow = sel_ovf ? o_ld_overflow : m_ld_overflow;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Little-endian packing of stream bytes, unfilled lanes zero.
   function automatic logic [31:0] pack_word(input int first, input int w, input int n);
      logic [31:0] word = '0;
      for (int b = 0; b < 4; b++) begin
         if (4 * w + b < n) word[8*b +: 8] = stream[first + 4*w + b];
      end
      return word;
   endfunction

   task automatic model_load(input int n);
      for (int w = 0; w < (n + 3) / 4; w++) begin
         exp_mem[w]   = pack_word(0, w, n);
         exp_valid[w] = 1'b1;
      end
   endtask

   task automatic check_word(input string tag, input int idx, input logic [31:0] exp);
      int depth = sel_ovf ? OvfDepth : MainDepth;
      addr_i = 32'(idx * 4 + depth * 4 * $urandom_range(0, 3));
      addr_d = 32'(idx * 4 + $urandom_range(0, 3) + depth * 4 * $urandom_range(0, 7));
      #1;
      check_eq({tag, " inst"}, c_inst, exp);
      check_eq({tag, " rdata"}, c_rdata, exp);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; wen = 1'b0;
      #1;
      check_eq("rst core_rst_n", 32'(c_core_rst_n), 32'd0);
      check_eq("rst load_done", 32'(c_load_done), 32'd0);
      check_eq("rst overflow", 32'(c_ld_overflow), 32'd0);
      check_eq("rst skip load_done", 32'(s_load_done), 32'd1);
      check_eq("rst skip core_rst_n", 32'(s_core_rst_n), 32'd0);
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("skip core_rst_n after rst", 32'(s_core_rst_n), 32'd1);
      check_eq("ld_ready after rst", 32'(c_ld_ready), 32'd1);
      check_eq("core_rst_n after rst", 32'(c_core_rst_n), 32'd0);
   endtask

   task automatic send_stream(input int first, input int n, input bit with_last, input int max_gap);
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         int gap = $urandom_range(0, max_gap);
         for (int g = 0; g < gap; g++) begin
            ld_valid = 1'b0;
            #1 check_eq("gap ld_ready", 32'(c_ld_ready), 32'd1);
            @(posedge clk); #1;
         end
         ld_valid = 1'b1;
         ld_byte  = stream[first + i];
         ld_last  = with_last && (i == n - 1);
         #1 check_eq("byte ld_ready", 32'(c_ld_ready), 32'd1);
         @(posedge clk); #1;
         ld_valid = 1'b0;
         ld_last  = 1'b0;
         check_eq("load core_rst_n", 32'(c_core_rst_n), 32'd0);
         check_eq("load_done", 32'(c_load_done), 32'(with_last && (i == n - 1)));
      end
      if (with_last) begin
         @(posedge clk); #1;
         check_eq("core_rst_n after load", 32'(c_core_rst_n), 32'd1);
      end
   endtask

   task automatic core_write(input logic [31:0] addr, input logic [31:0] data, input bit running);
      int idx = int'((addr >> 2) % MainDepth);
      @(posedge clk); #1;
      addr_d = addr; addr_i = addr; wdata = data; wen = 1'b1;
      #1;
      if (exp_valid[idx]) begin
         check_eq("wr old rdata", c_rdata, exp_mem[idx]);
         check_eq("wr old inst", c_inst, exp_mem[idx]);
      end
      @(posedge clk); #1;
      wen = 1'b0;
      if (running) begin
         exp_mem[idx]   = data;
         exp_valid[idx] = 1'b1;
      end
      if (exp_valid[idx]) begin
         check_eq("wr new rdata", c_rdata, exp_mem[idx]);
         check_eq("wr new inst", c_inst, exp_mem[idx]);
      end
   endtask

   initial begin
      logic [7:0] plan [8];
      plan = '{8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      rst_n = 1'b0; sel_ovf = 1'b0; wen = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
      ld_byte = 8'h0; addr_i = '0; addr_d = '0; wdata = '0;
      for (int i = 0; i < int'(MainDepth); i++) exp_valid[i] = 1'b0;

      // Directed two-word program.
      do_reset();
      for (int i = 0; i < 8; i++) stream[i] = plan[i];
      send_stream(0, 8, 1'b1, 0);
      model_load(8);
      check_word("plan w0", 0, 32'h00a00513);
      check_word("plan w1", 1, 32'h00100593);
      addr_i = 32'h0;
      #1 check_eq("plan inst@0", c_inst, 32'h00a00513);

      // Partial word on last, committed once.
      do_reset();
      stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33;
      send_stream(0, 3, 1'b1, 0);
      model_load(3);
      check_word("partial w0", 0, 32'h00332211);
      check_word("partial w1 kept", 1, exp_mem[1]);

      // Gapless vs gapped streaming of the same random image.
      for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
      do_reset();
      send_stream(0, 16, 1'b1, 0);
      model_load(16);
      for (int w = 0; w < 4; w++) check_word("gapless", w, exp_mem[w]);
      do_reset();
      send_stream(0, 16, 1'b1, 5);
      for (int w = 0; w < 4; w++) check_word("gapped", w, exp_mem[w]);

      // Core writes in RUN, including byte-offset and aliased reads.
      core_write(32'h10, 32'hdeadbeef, 1'b1);
      addr_d = 32'h13;
      #1 check_eq("rd 0x13", c_rdata, 32'hdeadbeef);
      addr_d = 32'h110;
      #1 check_eq("rd alias 0x110", c_rdata, 32'hdeadbeef);
      for (int k = 0; k < 12; k++) core_write($urandom, $urandom, 1'b1);

      // Core write during LOAD is ignored.
      do_reset();
      core_write(32'h10, 32'h12345678, 1'b0);
      for (int i = 0; i < 4; i++) stream[i] = 8'($urandom);
      send_stream(0, 4, 1'b1, 2);
      model_load(4);
      check_word("post-load w0", 0, exp_mem[0]);
      check_word("post-load w4", 4, exp_mem[4]);

      // Reset mid-load, then restream.
      do_reset();
      for (int i = 0; i < 6; i++) stream[i] = 8'($urandom);
      send_stream(0, 6, 1'b0, 2);
      exp_mem[0] = pack_word(0, 0, 6);
      check_word("midload w0", 0, exp_mem[0]);
      do_reset();
      for (int i = 0; i < 8; i++) stream[i] = 8'($urandom);
      send_stream(0, 8, 1'b1, 1);
      model_load(8);
      check_word("restream w0", 0, exp_mem[0]);
      check_word("restream w1", 1, exp_mem[1]);
      check_word("restream w2 kept", 2, exp_mem[2]);

      // Overflow on a 4-word instance.
      sel_ovf = 1'b1;
      do_reset();
      for (int i = 0; i < 20; i++) stream[i] = 8'($urandom);
      send_stream(0, 16, 1'b0, 1);
      check_eq("ovf before 5th", 32'(c_ld_overflow), 32'd0);
      send_stream(16, 4, 1'b1, 1);
      check_eq("ovf after 5th", 32'(c_ld_overflow), 32'd1);
      check_eq("ovf load_done", 32'(c_load_done), 32'd1);
      for (int w = 0; w < 4; w++) check_word("ovf word", w, pack_word(0, w, 20));
      @(posedge clk); #1;
      ld_valid = 1'b1; ld_byte = 8'hff; ld_last = 1'b1;
      #1 check_eq("run ld_ready", 32'(c_ld_ready), 32'd0);
      @(posedge clk); #1;
      ld_valid = 1'b0; ld_last = 1'b0;
      check_word("run ignores loader", 0, pack_word(0, 0, 20));
      check_eq("ovf sticky", 32'(c_ld_overflow), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
